// File: rtl/can_tx_priority_sel.sv
// ---------------------------------------------------------------------------
// can_tx_priority_sel
//
// Purpose:
//   Selects the next CAN message to transmit, then hands it to the bit stream
//   processor (BSP). A pending message in the high-priority buffer (HPB) always
//   wins over the TX FIFO. The selected word is popped, latched, offered with a
//   valid/ack handshake, and the BSP result is reported as a txok/txfail pulse.
//
// Optional feature (compile-time macro):
//   CAN_TX_RETRY_EN - when defined, a failed frame is re-offered up to
//   RETRY_LIMIT more times before it is dropped. When undefined, the first
//   failure drops the message and o_retry_cnt stays 0.
//
// Parameters:
//   RETRY_LIMIT      retransmissions allowed after the first attempt (0..15)
//
// Ports:
//   i_sys_clk        system clock, all state changes on its rising edge
//   i_reset          asynchronous active-high reset
//   i_tx_fifo_empty  TX FIFO has no message
//   o_tx_fifo_r_en   one-cycle TX FIFO pop
//   i_tx_fifo_r_data TX FIFO word, valid the cycle after o_tx_fifo_r_en
//   i_hpb_full       HPB holds a message
//   o_hpb_r_en       one-cycle HPB read/clear
//   i_hpb_data       HPB word, valid the cycle after o_hpb_r_en
//   i_tx_enable      core enabled; gates only the start of a new read
//   o_tx_message     message offered to the BSP (ID in [127:96])
//   o_tx_valid       o_tx_message is being offered
//   i_bsp_tx_ack     BSP accepted the offered message
//   i_bsp_tx_done    pulse: frame sent and acknowledged
//   i_bsp_tx_fail    pulse: arbitration lost or error frame
//   o_txok           pulse: message transmitted
//   o_txfail         pulse: message dropped
//   o_txbsy          high whenever a message is in progress
//   o_retry_cnt      retries consumed for the current message
// ---------------------------------------------------------------------------
module can_tx_priority_sel #(
  parameter int unsigned RETRY_LIMIT = 3
) (
  input  logic         i_sys_clk,
  input  logic         i_reset,
  input  logic         i_tx_fifo_empty,
  output logic         o_tx_fifo_r_en,
  input  logic [127:0] i_tx_fifo_r_data,
  input  logic         i_hpb_full,
  output logic         o_hpb_r_en,
  input  logic [127:0] i_hpb_data,
  input  logic         i_tx_enable,
  output logic [127:0] o_tx_message,
  output logic         o_tx_valid,
  input  logic         i_bsp_tx_ack,
  input  logic         i_bsp_tx_done,
  input  logic         i_bsp_tx_fail,
  output logic         o_txok,
  output logic         o_txfail,
  output logic         o_txbsy,
  output logic [3:0]   o_retry_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HPB,
    RD_FIFO,
    LATCH,
    OFFER,
    WAIT_RES
  } state_t;

  localparam logic [3:0] RETRY_MAX = 4'(RETRY_LIMIT);

`ifdef CAN_TX_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  state_t     state;
  state_t     state_next;
  logic       src_hpb;
  logic [3:0] retry_cnt;
  logic       retry_ok;

  // A failed frame may be re-offered only while the retry budget lasts; with
  // the retry feature compiled out this is constant 0, so a failure always
  // drops the message and the counter never moves.
  assign retry_ok    = RETRY_EN && (retry_cnt < RETRY_MAX);
  assign o_retry_cnt = retry_cnt;

  // State register plus the datapath registers. The held message only changes
  // in LATCH, which is the cycle the source's read data is valid. Result
  // pulses are registered so they are clean single-cycle strobes.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      src_hpb      <= 1'b0;
      o_tx_message <= '0;
      retry_cnt    <= '0;
      o_txok       <= 1'b0;
      o_txfail     <= 1'b0;
    end else begin
      state    <= state_next;
      o_txok   <= 1'b0;
      o_txfail <= 1'b0;
      case (state)
        RD_HPB:  src_hpb <= 1'b1;
        RD_FIFO: src_hpb <= 1'b0;
        LATCH: begin
          o_tx_message <= src_hpb ? i_hpb_data : i_tx_fifo_r_data;
          retry_cnt    <= '0;
        end
        WAIT_RES: begin
          // Done takes precedence over a coincident fail.
          if (i_bsp_tx_done) begin
            o_txok <= 1'b1;
          end else if (i_bsp_tx_fail) begin
            if (retry_ok) begin
              retry_cnt <= retry_cnt + 4'd1;
            end else begin
              o_txfail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. Enable only gates leaving IDLE, so a message that has
  // already been read always runs to completion. The HPB is checked first so
  // it wins when both sources are pending in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_tx_enable) begin
          if (i_hpb_full) begin
            state_next = RD_HPB;
          end else if (!i_tx_fifo_empty) begin
            state_next = RD_FIFO;
          end
        end
      end
      RD_HPB:  state_next = LATCH;
      RD_FIFO: state_next = LATCH;
      LATCH:   state_next = OFFER;
      OFFER: begin
        if (i_bsp_tx_ack) begin
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (i_bsp_tx_done) begin
          state_next = IDLE;
        end else if (i_bsp_tx_fail) begin
          state_next = retry_ok ? OFFER : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so reset clears them at once.
  // A read state is only entered when its source reported data.
  always_comb begin
    o_hpb_r_en     = 1'b0;
    o_tx_fifo_r_en = 1'b0;
    o_tx_valid     = 1'b0;
    o_txbsy        = 1'b0;
    if (state == RD_HPB) begin
      o_hpb_r_en = 1'b1;
    end
    if (state == RD_FIFO) begin
      o_tx_fifo_r_en = 1'b1;
    end
    if (state == OFFER) begin
      o_tx_valid = 1'b1;
    end
    if (state != IDLE) begin
      o_txbsy = 1'b1;
    end
  end

endmodule

// File: tb/tb_can_tx_priority_sel.sv
// ---------------------------------------------------------------------------
// tb_can_tx_priority_sel
//
// Self-checking bench for can_tx_priority_sel. The bench plays the TX FIFO,
// the HPB and the bit stream processor. A message-level model (ordered list of
// expected messages, each with a planned number of BSP failures) predicts what
// must be offered, the retry count during each offer and the final result.
// Honours CAN_TX_RETRY_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_can_tx_priority_sel;

  localparam int TB_RETRY = 3;
`ifdef CAN_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  // Failures a message survives before being dropped.
  localparam int LIM = RETRY_EN ? TB_RETRY : 0;

  localparam logic [127:0] MSG_033 = 128'h0001_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] MSG_HPB = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [127:0] MSG_FIF = 128'h5A5A_1001_5A5A_1002_5A5A_1003_5A5A_1004;
  localparam logic [127:0] MSG_ACK = 128'hC0DE_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] MSG_RTY = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0044;
  localparam logic [127:0] MSG_ENA = 128'h0BAD_CAFE_0000_0000_0000_0000_0000_0038;
  localparam logic [127:0] MSG_RST = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0037;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty;
  logic         fifo_r_en;
  logic [127:0] fifo_r_data = '0;
  logic         hpb_full;
  logic         hpb_r_en;
  logic [127:0] hpb_data = '0;
  logic         tx_enable = 1'b0;
  logic [127:0] tx_message;
  logic         tx_valid;
  logic         bsp_ack = 1'b0;
  logic         bsp_done = 1'b0;
  logic         bsp_fail = 1'b0;
  logic         txok;
  logic         txfail;
  logic         txbsy;
  logic [3:0]   retry_cnt;

  can_tx_priority_sel #(.RETRY_LIMIT(TB_RETRY)) dut (
    .i_sys_clk        (clk),
    .i_reset          (rst),
    .i_tx_fifo_empty  (fifo_empty),
    .o_tx_fifo_r_en   (fifo_r_en),
    .i_tx_fifo_r_data (fifo_r_data),
    .i_hpb_full       (hpb_full),
    .o_hpb_r_en       (hpb_r_en),
    .i_hpb_data       (hpb_data),
    .i_tx_enable      (tx_enable),
    .o_tx_message     (tx_message),
    .o_tx_valid       (tx_valid),
    .i_bsp_tx_ack     (bsp_ack),
    .i_bsp_tx_done    (bsp_done),
    .i_bsp_tx_fail    (bsp_fail),
    .o_txok           (txok),
    .o_txfail         (txfail),
    .o_txbsy          (txbsy),
    .o_retry_cnt      (retry_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: messages in the order they must be transmitted, with the number of
  // BSP failures planned for each.
  logic [127:0] exp_msg[$];
  int           exp_plan[$];
  int           cur = 0;
  int           fail_total = 0;
  int           fail_base = 0;

  // Source models: a word-addressed FIFO and a one-entry HPB.
  logic [127:0] fifo_mem[0:63];
  logic [127:0] hpb_mem[0:3];
  int fifo_wr = 0;
  int fifo_rd = 0;
  int hpb_wr = 0;
  int hpb_rd = 0;

  assign fifo_empty = (fifo_wr == fifo_rd);
  assign hpb_full   = (hpb_wr != hpb_rd);

  // Synchronous-read sources: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_r_data <= fifo_mem[fifo_rd[5:0]];
      fifo_rd     <= fifo_rd + 1;
    end
    if (hpb_r_en) begin
      hpb_data <= hpb_mem[hpb_rd[1:0]];
      hpb_rd   <= hpb_rd + 1;
    end
  end

  always @(posedge clk) begin
    if (bsp_fail) fail_total <= fail_total + 1;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit to_hpb, input logic [127:0] m, input int plan);
    if (to_hpb) begin
      hpb_mem[hpb_wr[1:0]] = m;
      hpb_wr++;
    end else begin
      fifo_mem[fifo_wr[5:0]] = m;
      fifo_wr++;
    end
    exp_msg.push_back(m);
    exp_plan.push_back(plan);
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (cur < exp_msg.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, cur >= exp_msg.size(), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [127:0] randMsg();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int randPlan();
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, 5));
  endfunction

  // BSP model: acks each offer after a delay, then answers with fail while the
  // message's planned failures last, otherwise done.
  typedef enum {D_IDLE, D_WAITACK, D_ACKED, D_WAITRES, D_PULSED, D_HOLD} drv_t;
  int   ack_fixed = 2;
  int   ack_max = 3;
  bit   hold_result = 1'b0;
  drv_t phase = D_IDLE;
  int   drv_idx = 0;
  int   fails_given = 0;
  int   dly = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bsp_ack = 1'b0;
        bsp_done = 1'b0;
        bsp_fail = 1'b0;
        phase = D_IDLE;
        drv_idx = exp_msg.size();
        fails_given = 0;
      end else begin
        case (phase)
          D_IDLE: begin
            if (tx_valid) begin
              dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, ack_max));
              if (dly == 0) begin
                bsp_ack = 1'b1;
                phase = D_ACKED;
              end else begin
                phase = D_WAITACK;
              end
            end
          end
          D_WAITACK: begin
            dly--;
            if (dly <= 0) begin
              bsp_ack = 1'b1;
              phase = D_ACKED;
            end
          end
          D_ACKED: begin
            bsp_ack = 1'b0;
            dly = int'($urandom_range(0, 2));
            phase = hold_result ? D_HOLD : D_WAITRES;
          end
          D_WAITRES: begin
            if (dly == 0) begin
              if (drv_idx < exp_msg.size() && fails_given < exp_plan[drv_idx]) begin
                bsp_fail = 1'b1;
                fails_given++;
              end else begin
                bsp_done = 1'b1;
              end
              phase = D_PULSED;
            end else begin
              dly--;
            end
          end
          D_PULSED: begin
            bsp_done = 1'b0;
            bsp_fail = 1'b0;
            if (txok || txfail) begin
              drv_idx++;
              fails_given = 0;
            end
            phase = D_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Compare process: every cycle, check the DUT against the message model.
  initial begin
    int  fails_seen;
    int  p;
    bit  exp_ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = exp_msg.size();
        fail_base = fail_total;
      end else begin
        fails_seen = fail_total - fail_base;
        if (fifo_r_en) checkOutput("fifo_ren_with_data", fifo_empty, 1'b0);
        if (hpb_r_en) checkOutput("hpb_ren_with_data", hpb_full, 1'b1);
        if (!RETRY_EN) checkOutput("retry_cnt_stays_zero", retry_cnt, 0);
        if (tx_valid) begin
          checkOutput("valid_implies_busy", txbsy, 1'b1);
          checkOutput("offer_expected", cur < exp_msg.size(), 1'b1);
          if (cur < exp_msg.size()) begin
            checkOutput("offer_message", tx_message, exp_msg[cur]);
            checkOutput("offer_retry_cnt", retry_cnt, RETRY_EN ? fails_seen : 0);
          end
        end
        if (txok || txfail) begin
          checkOutput("result_expected", cur < exp_msg.size(), 1'b1);
          if (cur < exp_msg.size()) begin
            p = exp_plan[cur];
            exp_ok = (p <= LIM);
            checkOutput("result_kind", {txok, txfail}, exp_ok ? 2'b10 : 2'b01);
            checkOutput("result_fail_count", fails_seen, exp_ok ? p : LIM + 1);
            cur++;
            fail_base = fail_total;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    int n_offers;
    int offer_rc[0:7];
    bit prev_valid;
    int nh;
    int nf;

    // Reset state.
    rst = 1'b1;
    tx_enable = 1'b0;
    @(negedge clk);
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_txbsy", txbsy, 1'b0);
    checkOutput("rst_txok", txok, 1'b0);
    checkOutput("rst_txfail", txfail, 1'b0);
    checkOutput("rst_retry_cnt", retry_cnt, 4'd0);
    checkOutput("rst_tx_message", tx_message, 128'd0);
    checkOutput("rst_fifo_ren", fifo_r_en, 1'b0);
    checkOutput("rst_hpb_ren", hpb_r_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single FIFO message: read on cycle 1, offered on cycle 3 after decision.
    ack_fixed = 2;
    applyStimulus(1'b0, MSG_033, 0);
    @(negedge clk);
    tx_enable = 1'b1;
    @(negedge clk);
    checkOutput("fifo_ren_pulse", fifo_r_en, 1'b1);
    checkOutput("fifo_path_no_hpb_ren", hpb_r_en, 1'b0);
    @(negedge clk);
    checkOutput("fifo_ren_single", fifo_r_en, 1'b0);
    checkOutput("valid_not_early", tx_valid, 1'b0);
    @(negedge clk);
    checkOutput("valid_after_3", tx_valid, 1'b1);
    checkOutput("first_data", tx_message, MSG_033);
    n = 0;
    while (!txok && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txok_seen", txok, 1'b1);
    checkOutput("busy_low_at_txok", txbsy, 1'b0);
    @(negedge clk);
    checkOutput("txok_single_pulse", txok, 1'b0);
    waitDone(50, "drain_single");

    // HPB and FIFO pending together: HPB is read and sent first.
    tx_enable = 1'b0;
    applyStimulus(1'b1, MSG_HPB, 0);
    applyStimulus(1'b0, MSG_FIF, 0);
    @(negedge clk);
    tx_enable = 1'b1;
    @(negedge clk);
    checkOutput("prio_hpb_ren", hpb_r_en, 1'b1);
    checkOutput("prio_no_fifo_ren", fifo_r_en, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("prio_first_msg", tx_message, MSG_HPB);
    waitDone(200, "drain_priority");

    // Ack delayed 10 cycles: offer must stay stable.
    tx_enable = 1'b0;
    ack_fixed = 10;
    applyStimulus(1'b0, MSG_ACK, 0);
    @(negedge clk);
    tx_enable = 1'b1;
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid_held", tx_valid, 1'b1);
      checkOutput("stall_msg_held", tx_message, MSG_ACK);
      @(negedge clk);
    end
    waitDone(100, "drain_stall");
    ack_fixed = 1;

    // Four consecutive failures.
    tx_enable = 1'b0;
    applyStimulus(1'b0, MSG_RTY, 4);
    @(negedge clk);
    tx_enable = 1'b1;
    n = 0;
    n_offers = 0;
    prev_valid = 1'b0;
    while (!(txok || txfail) && n < 300) begin
      @(negedge clk);
      n++;
      if (tx_valid && !prev_valid) begin
        if (n_offers < 8) offer_rc[n_offers] = int'(retry_cnt);
        n_offers++;
      end
      prev_valid = tx_valid;
    end
    checkOutput("retry_txfail", txfail, 1'b1);
    checkOutput("retry_no_txok", txok, 1'b0);
    checkOutput("retry_offer_count", n_offers, RETRY_EN ? TB_RETRY + 1 : 1);
    for (int k = 0; k < n_offers && k < 8; k++) begin
      checkOutput("retry_cnt_per_offer", offer_rc[k], k);
    end
    waitDone(50, "drain_retry");

    // Enable low blocks new reads; raising it starts the read.
    tx_enable = 1'b0;
    applyStimulus(1'b0, MSG_ENA, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_r_en || hpb_r_en) cnt++;
    end
    checkOutput("disabled_no_read", cnt, 0);
    tx_enable = 1'b1;
    @(negedge clk);
    checkOutput("enable_triggers_read", fifo_r_en, 1'b1);
    waitDone(100, "drain_enable");

    // Reset while waiting for the BSP result.
    tx_enable = 1'b0;
    hold_result = 1'b1;
    ack_fixed = 0;
    applyStimulus(1'b0, MSG_RST, 0);
    @(negedge clk);
    tx_enable = 1'b1;
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitres_busy", txbsy, 1'b1);
    checkOutput("waitres_msg_held", tx_message, MSG_RST);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", tx_valid, 1'b0);
    checkOutput("async_rst_busy", txbsy, 1'b0);
    checkOutput("async_rst_msg", tx_message, 128'd0);
    checkOutput("async_rst_retry", retry_cnt, 4'd0);
    checkOutput("async_rst_txok", txok, 1'b0);
    checkOutput("async_rst_txfail", txfail, 1'b0);
    checkOutput("async_rst_fifo_ren", fifo_r_en, 1'b0);
    checkOutput("async_rst_hpb_ren", hpb_r_en, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_result", {txok, txfail}, 2'b00);
    end
    rst = 1'b0;
    hold_result = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("after_rst_no_result", {txok, txfail}, 2'b00);
    end
    checkOutput("after_rst_idle", txbsy, 1'b0);

    // Randomized batches against the message model.
    ack_fixed = -1;
    for (int b = 0; b < 30; b++) begin
      @(negedge clk);
      tx_enable = 1'b0;
      ack_max = int'($urandom_range(0, 4));
      nh = int'($urandom_range(0, 1));
      nf = int'($urandom_range(0, 3));
      if (nh + nf == 0) nf = 1;
      if (nh == 1) applyStimulus(1'b1, randMsg(), randPlan());
      for (int k = 0; k < nf; k++) applyStimulus(1'b0, randMsg(), randPlan());
      @(negedge clk);
      tx_enable = 1'b1;
      n = 0;
      while (cur < exp_msg.size() && n < 1500) begin
        @(negedge clk);
        n++;
        if ($urandom_range(0, 9) == 0) begin
          tx_enable = 1'b0;
          repeat (int'($urandom_range(1, 4))) @(negedge clk);
          tx_enable = 1'b1;
        end
      end
      checkOutput("batch_drained", cur >= exp_msg.size(), 1'b1);
      repeat (2) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
